// File: rtl/jtdsp16_rom_loader.sv
// Byte-serial download of the DSP16 program ROM with a one-cycle write pipeline.
// Optional running byte checksum is built only with JTDSP16_ROM_CKSUM_EN defined.
module jtdsp16_rom_loader #(
  parameter int ROM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dl_start,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  input  logic        dl_last,
  output logic        dl_ready,
  output logic [12:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic        prog_we,
  output logic        dsp_rst,
  output logic        busy,
  output logic        done,
  output logic [13:0] count,
  output logic [15:0] cksum
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WLAST, ST_DONE} state_t;

  localparam logic [13:0] LAST_ADDR = 14'(ROM_BYTES - 1);

  state_t      state_q, state_d;
  logic [13:0] count_q, count_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d;
  logic        dsp_rst_q, dsp_rst_d;
  logic        accept;

  // dl_start wins over a byte offered in the same cycle.
  assign accept = (state_q == ST_LOAD) && dl_valid && !dl_start;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    dsp_rst_d = dsp_rst_q;
    if (dl_start) begin
      state_d   = ST_LOAD;
      count_d   = '0;
      dsp_rst_d = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            we_d    = 1'b1;
            addr_d  = count_q[12:0];
            data_d  = dl_data;
            count_d = count_q + 14'd1;
            if (dl_last || count_q == LAST_ADDR) state_d = ST_WLAST;
          end
        end
        ST_WLAST: begin
          // The last write is on the bus this cycle; release the core as DONE is entered.
          state_d   = ST_DONE;
          dsp_rst_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      dsp_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      dsp_rst_q <= dsp_rst_d;
    end
  end

`ifdef JTDSP16_ROM_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (dl_start)    cksum_d = '0;
    else if (accept) cksum_d = cksum_q + {8'd0, dl_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cksum_q <= '0;
    else        cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

  assign dl_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_WLAST);
  assign done      = (state_q == ST_DONE);
  assign prog_we   = we_q;
  assign prog_addr = addr_q;
  assign prog_data = data_q;
  assign dsp_rst   = dsp_rst_q;
  assign count     = count_q;

endmodule
